// File: rtl/flt_result_fix_fifo.sv
// flt_result_fix_fifo: converts IEEE-754 single-precision results from the
// reciprocal core (which cannot be stalled) into saturated signed fixed point.
// Results are buffered in a small FIFO and presented on an AXI4-Stream master.
//
// Ports:
//   i_aclk, i_areset_n        clock, asynchronous active-low reset
//   i_axi4s_result_tdata/vld  float beats from the core (no ready returned)
//   o_axi4s_fix_tdata/tvalid  head of FIFO (registered), valid = non-empty
//   i_axi4s_fix_tready        downstream ready
//   o_level                   FIFO occupancy
//   o_sat / o_nan             one-cycle pulses aligned with the write becoming visible
//   o_drop_err                sticky, a result was lost on a full FIFO
//
// Latency: 2 cycles from input to tvalid (empty FIFO), throughput one per cycle.
// Optional macro FLT2FIX_ROUND_NEAREST_EN: round-to-nearest-even on right shifts
// instead of truncation toward zero.
module flt_result_fix_fifo #(
   parameter int OUT_WIDTH  = 32,
   parameter int FRAC_BITS  = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        i_aclk,
   input  logic                        i_areset_n,
   input  logic [31:0]                 i_axi4s_result_tdata,
   input  logic                        i_axi4s_result_tvalid,
   output logic [OUT_WIDTH-1:0]        o_axi4s_fix_tdata,
   output logic                        o_axi4s_fix_tvalid,
   input  logic                        i_axi4s_fix_tready,
   output logic [$clog2(FIFO_DEPTH):0] o_level,
   output logic                        o_sat,
   output logic                        o_nan,
   output logic                        o_drop_err
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);

   // k = e - 150 + FRAC_BITS; 10 signed bits cover -150..136
   localparam logic signed [9:0] K_BIAS = 10'(FRAC_BITS - 150);

   localparam logic [OUT_WIDTH-1:0] FIX_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] FIX_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
   // Largest representable magnitudes for each sign, for the saturation compare
   localparam logic [63:0] MAG_MAX_POS = {{(64-OUT_WIDTH){1'b0}}, FIX_MAX};
   localparam logic [63:0] MAG_MAX_NEG = {{(64-OUT_WIDTH){1'b0}}, FIX_MIN};
   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      CLS_ZERO,   // zero or denormal
      CLS_INF,
      CLS_NAN,
      CLS_NORM
   } cls_t;

   // ---------------- input decode ----------------
   logic [7:0]  in_exp;
   logic [22:0] in_frac;
   cls_t        in_cls;

   assign in_exp  = i_axi4s_result_tdata[30:23];
   assign in_frac = i_axi4s_result_tdata[22:0];

   always_comb begin
      in_cls = CLS_NORM;
      if (in_exp == 8'd0) begin
         in_cls = CLS_ZERO;
      end else if (in_exp == 8'hFF) begin
         in_cls = (in_frac == 23'd0) ? CLS_INF : CLS_NAN;
      end
   end

   // ---------------- stage 1 registers ----------------
   logic              s1_vld;
   logic              s1_sign;
   logic [23:0]       s1_mant;
   cls_t              s1_cls;
   logic signed [9:0] s1_k;

   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         s1_vld  <= 1'b0;
         s1_sign <= 1'b0;
         s1_mant <= '0;
         s1_cls  <= CLS_ZERO;
         s1_k    <= '0;
      end else begin
         s1_vld <= i_axi4s_result_tvalid;
         // data registers only load on a valid beat; idle tdata is ignored
         if (i_axi4s_result_tvalid) begin
            s1_sign <= i_axi4s_result_tdata[31];
            s1_mant <= {1'b1, in_frac};
            s1_cls  <= in_cls;
            s1_k    <= $signed({2'b00, in_exp}) + K_BIAS;
         end
      end
   end

   // ---------------- stage 2: shift, round, saturate, sign ----------------
   logic [63:0]          mag;      // unsigned magnitude, wide enough for k <= 32
   logic                 huge;     // shift so large that any width saturates
   logic [5:0]           lsh;
   logic [5:0]           rsh;
   logic [OUT_WIDTH-1:0] s2_res;
   logic                 s2_sat;
   logic                 s2_nan;
`ifdef FLT2FIX_ROUND_NEAREST_EN
   logic [63:0]          shr;      // [63:40] integer part, [39] guard, [38:0] sticky
   logic                 rnd_up;
`endif

   always_comb begin
      mag    = '0;
      huge   = 1'b0;
      lsh    = '0;
      rsh    = '0;
      s2_res = '0;
      s2_sat = 1'b0;
      s2_nan = 1'b0;
`ifdef FLT2FIX_ROUND_NEAREST_EN
      shr    = '0;
      rnd_up = 1'b0;
`endif

      if (s1_k >= 10'sd0) begin
         if (s1_k > 10'sd32) begin
            huge = 1'b1;
         end else begin
            lsh = s1_k[5:0];
            mag = {40'b0, s1_mant} << lsh;
         end
      end else if (s1_k > -10'sd25) begin
         // -k is 1..24 here, so the low six bits negated give the shift
         rsh = 6'd0 - s1_k[5:0];
`ifdef FLT2FIX_ROUND_NEAREST_EN
         shr    = {s1_mant, 40'b0} >> rsh;
         rnd_up = shr[39] & ((|shr[38:0]) | shr[40]);
         // a round-up past the limit is caught by the saturation compare below
         mag    = {40'b0, shr[63:40]} + {63'b0, rnd_up};
`else
         mag = {40'b0, s1_mant >> rsh};
`endif
      end
      // k <= -25: every mantissa bit shifts out, magnitude stays 0

      case (s1_cls)
         CLS_ZERO: s2_res = '0;
         CLS_NAN: begin
            s2_res = '0;
            s2_nan = 1'b1;
         end
         CLS_INF: begin
            s2_res = s1_sign ? FIX_MIN : FIX_MAX;
            s2_sat = 1'b1;
         end
         default: begin
            if (s1_sign) begin
               // exactly -2^(W-1) is representable, so only strictly larger saturates
               if (huge || (mag > MAG_MAX_NEG)) begin
                  s2_res = FIX_MIN;
                  s2_sat = 1'b1;
               end else begin
                  s2_res = -mag[OUT_WIDTH-1:0];
               end
            end else begin
               if (huge || (mag > MAG_MAX_POS)) begin
                  s2_res = FIX_MAX;
                  s2_sat = 1'b1;
               end else begin
                  s2_res = mag[OUT_WIDTH-1:0];
               end
            end
         end
      endcase
   end

   // ---------------- FIFO ----------------
   logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W:0]      wr_ptr;
   logic [ADDR_W:0]      rd_ptr;
   logic                 empty;
   logic                 full;
   logic                 rd_en;
   logic                 wr_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign rd_en = !empty && i_axi4s_fix_tready;
   // a read in the same cycle frees the slot, so a full FIFO still accepts
   assign wr_en = s1_vld && (!full || rd_en);

   assign o_axi4s_fix_tvalid = !empty;
   assign o_axi4s_fix_tdata  = mem[rd_ptr[ADDR_W-1:0]];
   assign o_level            = wr_ptr - rd_ptr;

   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_sat      <= 1'b0;
         o_nan      <= 1'b0;
         o_drop_err <= 1'b0;
         // storage is cleared so tdata reads 0 out of reset
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= s2_res;
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         // flags only report values that actually landed in the FIFO
         o_sat <= wr_en & s2_sat;
         o_nan <= wr_en & s2_nan;
         if (s1_vld && !wr_en) begin
            o_drop_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_flt_result_fix_fifo.sv
// Directed bench for flt_result_fix_fifo (OUT_WIDTH=32, FRAC_BITS=16, FIFO_DEPTH=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_flt_result_fix_fifo;

   logic        aclk;
   logic        areset_n;
   logic [31:0] res_dat;
   logic        res_vld;
   logic [31:0] fix_dat;
   logic        fix_vld;
   logic        fix_rdy;
   logic [3:0]  level;
   logic        sat;
   logic        nan;
   logic        drop_err;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] expq[$];
   int          sent;
   int          got;
   int          cyc;
   logic        r;

`ifdef FLT2FIX_ROUND_NEAREST_EN
   localparam logic [31:0] EXP_1P5_SMALL = 32'd2;
`else
   localparam logic [31:0] EXP_1P5_SMALL = 32'd1;
`endif

   flt_result_fix_fifo #(
      .OUT_WIDTH  (32),
      .FRAC_BITS  (16),
      .FIFO_DEPTH (8)
   ) dut (
      .i_aclk                (aclk),
      .i_areset_n            (areset_n),
      .i_axi4s_result_tdata  (res_dat),
      .i_axi4s_result_tvalid (res_vld),
      .o_axi4s_fix_tdata     (fix_dat),
      .o_axi4s_fix_tvalid    (fix_vld),
      .i_axi4s_fix_tready    (fix_rdy),
      .o_level               (level),
      .o_sat                 (sat),
      .o_nan                 (nan),
      .o_drop_err            (drop_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // 1 + i/128 as a float; in Q16.16 that is exactly 0x10000 + 512*i
   function automatic logic [31:0] flt(input int i);
      return 32'h3F80_0000 + (32'(i) << 16);
   endfunction

   function automatic logic [31:0] fixv(input int i);
      return 32'h0001_0000 + (32'(i) << 9);
   endfunction

   // single conversion into an empty FIFO with tready held high
   task automatic conv(input string tag, input logic [31:0] din, input logic [31:0] exp,
                       input logic exp_sat, input logic exp_nan);
      res_vld = 1'b1;
      res_dat = din;
      tick();
      res_vld = 1'b0;
      res_dat = 32'hDEAD_BEEF;
      check({tag, "_lat1"}, fix_vld, 0);
      tick();
      check({tag, "_vld"}, fix_vld, 1);
      check({tag, "_dat"}, fix_dat, exp);
      check({tag, "_sat"}, sat, exp_sat);
      check({tag, "_nan"}, nan, exp_nan);
      tick();
      check({tag, "_pulse_end"}, {sat, nan, fix_vld}, 0);
   endtask

   initial begin
      areset_n = 1'b0;
      res_vld  = 1'b0;
      res_dat  = '0;
      fix_rdy  = 1'b0;

      // ---- reset state ----
      #3;
      check("rst_vld", fix_vld, 0);
      check("rst_level", level, 0);
      check("rst_dat", fix_dat, 0);
      check("rst_flags", {sat, nan, drop_err}, 0);
      #23 areset_n = 1'b1;
      tick();

      // ---- back-to-back conversion, latency ----
      fix_rdy = 1'b1;
      res_vld = 1'b1;
      res_dat = 32'h3FC0_0000;      // 1.5
      tick();
      check("cv_lat1", fix_vld, 0);
      res_dat = 32'hBE80_0000;      // -0.25
      tick();
      res_vld = 1'b0;
      check("cv_vld", fix_vld, 1);
      check("cv_1p5", fix_dat, 32'h0001_8000);
      tick();
      check("cv_vld2", fix_vld, 1);
      check("cv_m0p25", fix_dat, 32'hFFFF_C000);
      tick();
      check("cv_empty", fix_vld, 0);

      // ---- saturation, specials, small values ----
      conv("big",      32'h5015_02F9, 32'h7FFF_FFFF, 1'b1, 1'b0);
      conv("ninf",     32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0);
      conv("pinf",     32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
      conv("nan",      32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1);
      conv("p2m16",    32'h3780_0000, 32'h0000_0001, 1'b0, 1'b0);
      conv("p1p5m16",  32'h37C0_0000, EXP_1P5_SMALL, 1'b0, 1'b0);
      conv("p2m17",    32'h3700_0000, 32'h0000_0000, 1'b0, 1'b0);
      conv("denorm",   32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
      conv("nminexact",32'hC700_0000, 32'h8000_0000, 1'b0, 1'b0);   // -32768
      conv("pminsat",  32'h4700_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);   // +32768
      conv("p1000",    32'h447A_0000, 32'h03E8_0000, 1'b0, 1'b0);
      conv("nzero",    32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);

      // ---- full and drop ----
      fix_rdy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         res_vld = 1'b1;
         res_dat = flt(i);
         tick();
      end
      res_vld = 1'b0;
      tick(); tick(); tick();
      check("full_level", level, 8);
      check("full_drop", drop_err, 1);
      fix_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_%0d", i), {fix_vld, fix_dat}, {1'b1, fixv(i)});
         tick();
      end
      check("drain_empty", fix_vld, 0);
      check("drain_drop_held", drop_err, 1);

      // ---- asynchronous reset with 5 entries stored ----
      fix_rdy = 1'b0;
      for (int i = 20; i < 25; i++) begin
         res_vld = 1'b1;
         res_dat = flt(i);
         tick();
      end
      res_vld = 1'b0;
      tick(); tick();
      check("mid_level", level, 5);
      #2 areset_n = 1'b0;
      #1;
      check("arst_vld", fix_vld, 0);
      check("arst_level", level, 0);
      check("arst_drop", drop_err, 0);
      #2 areset_n = 1'b1;
      tick();
      fix_rdy = 1'b1;
      conv("post_rst", flt(30), fixv(30), 1'b0, 1'b0);

      // ---- simultaneous read and write while full ----
      fix_rdy = 1'b0;
      for (int i = 40; i < 48; i++) begin
         res_vld = 1'b1;
         res_dat = flt(i);
         tick();
      end
      res_vld = 1'b0;
      tick(); tick();
      check("sim_full", level, 8);
      res_vld = 1'b1;
      res_dat = flt(48);
      tick();
      res_vld = 1'b0;
      fix_rdy = 1'b1;            // read on the same edge the 9th value is written
      tick();
      fix_rdy = 1'b0;
      check("sim_level", level, 8);
      check("sim_nodrop", drop_err, 0);
      fix_rdy = 1'b1;
      for (int i = 41; i < 49; i++) begin
         check($sformatf("sim_drain_%0d", i), {fix_vld, fix_dat}, {1'b1, fixv(i)});
         tick();
      end
      check("sim_empty", fix_vld, 0);

      // ---- pointer wrap with random tready ----
      sent = 0;
      got  = 0;
      cyc  = 0;
      while (got < 20 && cyc < 2000) begin
         r = ($urandom_range(0, 3) != 0);
         fix_rdy = r;
         if (fix_vld && r) begin
            if (expq.size() == 0) check("wrap_extra", 1, 0);
            else check("wrap_dat", fix_dat, expq.pop_front());
            got++;
         end
         if (sent < 20 && level < 5 && $urandom_range(0, 1) == 1) begin
            res_vld = 1'b1;
            res_dat = flt(60 + sent);
            expq.push_back(fixv(60 + sent));
            sent++;
         end else begin
            res_vld = 1'b0;
         end
         tick();
         cyc++;
      end
      res_vld = 1'b0;
      fix_rdy = 1'b0;
      check("wrap_count", got, 20);
      check("wrap_nodrop", drop_err, 0);
      check("wrap_level", level, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
